// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage: load-type codes, FSM encoding,
// default parameters and the sign-extension helpers used by the load aligner.
package wb_pkg;

   localparam int DEFAULT_REG_AW  = 6;
   localparam int DEFAULT_MD_W    = 64;
   localparam int DEFAULT_TIMEOUT = 16;

   localparam logic [2:0] LOAD_LW  = 3'd0;
   localparam logic [2:0] LOAD_LB  = 3'd1;
   localparam logic [2:0] LOAD_LBU = 3'd2;
   localparam logic [2:0] LOAD_LH  = 3'd3;
   localparam logic [2:0] LOAD_LHU = 3'd4;
   localparam logic [2:0] LOAD_LWL = 3'd5;
   localparam logic [2:0] LOAD_LWR = 3'd6;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_MEM = 2'd1,
      ST_COMMIT   = 2'd2
   } state_t;

   function automatic logic [31:0] sext8(input logic [7:0] b);
      return {{24{b[7]}}, b};
   endfunction

   function automatic logic [31:0] sext16(input logic [15:0] h);
      return {{16{h[15]}}, h};
   endfunction

endpackage

// File: rtl/wb_stage_pipe_if.sv
// Bundle between mem stage / data memory (master) and the writeback stage (slave).
// With WB_FWD_EN defined the slave also exports the forwarding/pending signals.
interface wb_stage_pipe_if
   import wb_pkg::*;
#(
   parameter int REG_AW = DEFAULT_REG_AW,
   parameter int MD_W   = DEFAULT_MD_W
);
   logic              stop;
   logic              in_valid;
   logic              in_ready;
   logic              in_reg_en;
   logic [REG_AW-1:0] in_reg_waddr;
   logic              in_mem_read;
   logic [2:0]        in_load_type;
   logic [31:0]       in_alu_result;
   logic [31:0]       in_rt_data;
   logic              in_MD_complete;
   logic [MD_W-1:0]   in_MD_result;
   logic              mem_rvalid;
   logic [31:0]       mem_rdata;
   logic              wb_reg_en;
   logic [REG_AW-1:0] wb_reg_waddr;
   logic [31:0]       wb_reg_wdata;
   logic              wb_MD_complete;
   logic [MD_W-1:0]   wb_MD_result;
   logic              wb_mem_err;
`ifdef WB_FWD_EN
   logic              fwd_valid;
   logic              fwd_pending;
   logic [REG_AW-1:0] fwd_waddr;
   logic [31:0]       fwd_wdata;
`endif

   modport master (
      output stop, in_valid, in_reg_en, in_reg_waddr, in_mem_read, in_load_type,
             in_alu_result, in_rt_data, in_MD_complete, in_MD_result,
             mem_rvalid, mem_rdata,
      input  in_ready, wb_reg_en, wb_reg_waddr, wb_reg_wdata,
             wb_MD_complete, wb_MD_result, wb_mem_err
`ifdef WB_FWD_EN
      , input fwd_valid, fwd_pending, fwd_waddr, fwd_wdata
`endif
   );

   modport slave (
      input  stop, in_valid, in_reg_en, in_reg_waddr, in_mem_read, in_load_type,
             in_alu_result, in_rt_data, in_MD_complete, in_MD_result,
             mem_rvalid, mem_rdata,
      output in_ready, wb_reg_en, wb_reg_waddr, wb_reg_wdata,
             wb_MD_complete, wb_MD_result, wb_mem_err
`ifdef WB_FWD_EN
      , output fwd_valid, fwd_pending, fwd_waddr, fwd_wdata
`endif
   );

endinterface

// File: rtl/wb_load_align.sv
// Combinational load-data alignment and extension for LW/LB/LBU/LH/LHU/LWL/LWR.
// Also reused by the mem stage to check store data.
module wb_load_align
   import wb_pkg::*;
(
   input  logic [2:0]  load_type,
   input  logic [1:0]  off,
   input  logic [31:0] rdata,
   input  logic [31:0] rt,
   output logic [31:0] result
);

   logic [7:0]  lane [4];
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic        half_ok;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign lane[gi] = rdata[8*gi +: 8];
      end
   endgenerate

   assign byte_sel = lane[off];
   assign half_sel = off[1] ? rdata[31:16] : rdata[15:0];
   // Misaligned halfword reads return zero rather than a split value.
   assign half_ok  = ~off[0];

   always_comb begin
      result = '0;
      case (load_type)
         LOAD_LW:  result = rdata;
         LOAD_LB:  result = sext8(byte_sel);
         LOAD_LBU: result = {24'd0, byte_sel};
         LOAD_LH:  result = half_ok ? sext16(half_sel) : 32'd0;
         LOAD_LHU: result = half_ok ? {16'd0, half_sel} : 32'd0;
         LOAD_LWL: begin
            case (off)
               2'd0:    result = {rdata[7:0],  rt[23:0]};
               2'd1:    result = {rdata[15:0], rt[15:0]};
               2'd2:    result = {rdata[23:0], rt[7:0]};
               default: result = rdata;
            endcase
         end
         LOAD_LWR: begin
            case (off)
               2'd0:    result = rdata;
               2'd1:    result = {rt[31:24], rdata[31:8]};
               2'd2:    result = {rt[31:16], rdata[31:16]};
               default: result = {rt[31:8],  rdata[31:24]};
            endcase
         end
         default:  result = '0;
      endcase
   end

endmodule

// File: rtl/wb_stage_pipe.sv
// Buffered writeback stage: accepts one instruction, waits (bounded) for load data,
// aligns it and commits to GPR / HI-LO under downstream stall. Optional WB_FWD_EN.
module wb_stage_pipe
   import wb_pkg::*;
#(
   parameter int REG_AW  = DEFAULT_REG_AW,
   parameter int MD_W    = DEFAULT_MD_W,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
)
(
   input  logic           clk,
   input  logic           reset,
   wb_stage_pipe_if.slave bus
);

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t            state_reg, state_next;
   logic              held_reg_en_reg, held_reg_en_next;
   logic [REG_AW-1:0] held_waddr_reg, held_waddr_next;
   logic [2:0]        held_load_type_reg, held_load_type_next;
   logic [1:0]        held_off_reg, held_off_next;
   logic [31:0]       held_rt_reg, held_rt_next;
   logic              held_md_reg, held_md_next;
   logic [MD_W-1:0]   held_md_result_reg, held_md_result_next;
   logic [31:0]       wdata_reg, wdata_next;
   logic [7:0]        cnt_reg, cnt_next;
   logic              mem_err_reg, mem_err_next;

   logic              in_commit;
   logic              accept;
   logic [31:0]       align_result;

   assign in_commit    = (state_reg == ST_COMMIT);
   assign bus.in_ready = (state_reg == ST_IDLE) | (in_commit & ~bus.stop);
   assign accept       = bus.in_valid & bus.in_ready;

   // Alignment works from the held offset/type/rt so the response can arrive any cycle later.
   wb_load_align u_align (
      .load_type (held_load_type_reg),
      .off       (held_off_reg),
      .rdata     (bus.mem_rdata),
      .rt        (held_rt_reg),
      .result    (align_result)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg          <= ST_IDLE;
         held_reg_en_reg    <= 1'b0;
         held_waddr_reg     <= '0;
         held_load_type_reg <= '0;
         held_off_reg       <= '0;
         held_rt_reg        <= '0;
         held_md_reg        <= 1'b0;
         held_md_result_reg <= '0;
         wdata_reg          <= '0;
         cnt_reg            <= '0;
         mem_err_reg        <= 1'b0;
      end else begin
         state_reg          <= state_next;
         held_reg_en_reg    <= held_reg_en_next;
         held_waddr_reg     <= held_waddr_next;
         held_load_type_reg <= held_load_type_next;
         held_off_reg       <= held_off_next;
         held_rt_reg        <= held_rt_next;
         held_md_reg        <= held_md_next;
         held_md_result_reg <= held_md_result_next;
         wdata_reg          <= wdata_next;
         cnt_reg            <= cnt_next;
         mem_err_reg        <= mem_err_next;
      end
   end

   always_comb begin
      state_next          = state_reg;
      held_reg_en_next    = held_reg_en_reg;
      held_waddr_next     = held_waddr_reg;
      held_load_type_next = held_load_type_reg;
      held_off_next       = held_off_reg;
      held_rt_next        = held_rt_reg;
      held_md_next        = held_md_reg;
      held_md_result_next = held_md_result_reg;
      wdata_next          = wdata_reg;
      cnt_next            = cnt_reg;
      mem_err_next        = 1'b0;

      case (state_reg)
         ST_IDLE: ;
         ST_WAIT_MEM: begin
            if (bus.mem_rvalid) begin
               wdata_next = align_result;
               state_next = ST_COMMIT;
            end else if (cnt_reg == CNT_LAST) begin
               // Abort: commit a no-op so the pipeline drains, flag the error once.
               mem_err_next     = 1'b1;
               held_reg_en_next = 1'b0;
               held_md_next     = 1'b0;
               wdata_next       = '0;
               state_next       = ST_COMMIT;
            end else begin
               cnt_next = cnt_reg + 8'd1;
            end
         end
         ST_COMMIT: begin
            if (!bus.stop) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase

      // in_ready already folds in state and stall, so accept overrides the retire above.
      if (accept) begin
         held_reg_en_next    = bus.in_reg_en;
         held_waddr_next     = bus.in_reg_waddr;
         held_load_type_next = bus.in_load_type;
         held_off_next       = bus.in_alu_result[1:0];
         held_rt_next        = bus.in_rt_data;
         held_md_next        = bus.in_MD_complete;
         held_md_result_next = bus.in_MD_result;
         cnt_next            = '0;
         if (bus.in_mem_read) begin
            state_next = ST_WAIT_MEM;
         end else begin
            wdata_next = bus.in_alu_result;
            state_next = ST_COMMIT;
         end
      end
   end

   assign bus.wb_reg_en      = in_commit & held_reg_en_reg & ~bus.stop;
   assign bus.wb_reg_waddr   = held_waddr_reg;
   assign bus.wb_reg_wdata   = wdata_reg;
   assign bus.wb_MD_complete = in_commit & held_md_reg & ~bus.stop;
   assign bus.wb_MD_result   = held_md_result_reg;
   assign bus.wb_mem_err     = mem_err_reg;

`ifdef WB_FWD_EN
   // Forwarding ignores stop so decode can bypass a stalled commit.
   assign bus.fwd_valid   = in_commit & held_reg_en_reg;
   assign bus.fwd_pending = (state_reg == ST_WAIT_MEM) & held_reg_en_reg;
   assign bus.fwd_waddr   = held_waddr_reg;
   assign bus.fwd_wdata   = wdata_reg;
`endif

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Scoreboard bench for wb_stage_pipe: stimulus pushes expected commits, a negedge
// monitor pops and compares every GPR/HI-LO/error event.
module tb_wb_stage_pipe;
   import wb_pkg::*;

   localparam int REG_AW  = 6;
   localparam int MD_W    = 64;
   localparam int TIMEOUT = 16;

   typedef struct {
      int          cyc;
      logic        reg_en;
      logic [5:0]  waddr;
      logic [31:0] wdata;
      logic        md;
      logic [63:0] md_result;
      logic        err;
      int          tag;
   } exp_t;

   typedef struct packed {
      logic [2:0]  lt;
      logic [1:0]  off;
      logic [31:0] rd;
      logic [31:0] rt;
      logic [31:0] exp;
      logic [3:0]  d;
   } ld_vec_t;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];
   exp_t mon_e;
   ld_vec_t ld_tab [12];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   wb_stage_pipe_if #(.REG_AW(REG_AW), .MD_W(MD_W)) bus ();

   wb_stage_pipe #(.REG_AW(REG_AW), .MD_W(MD_W), .TIMEOUT(TIMEOUT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   task automatic push_exp(input int c, input logic re, input logic [5:0] wa, input logic [31:0] wd,
                           input logic md, input logic [63:0] mdr, input logic er, input int tag);
      exp_t e;
      e.cyc = c; e.reg_en = re; e.waddr = wa; e.wdata = wd;
      e.md = md; e.md_result = mdr; e.err = er; e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic issue(input logic re, input logic [5:0] wa, input logic mr, input logic [2:0] lt,
                        input logic [31:0] alu, input logic [31:0] rt, input logic md,
                        input logic [63:0] mdr, output int acc);
      bus.in_reg_en = re; bus.in_reg_waddr = wa; bus.in_mem_read = mr; bus.in_load_type = lt;
      bus.in_alu_result = alu; bus.in_rt_data = rt; bus.in_MD_complete = md; bus.in_MD_result = mdr;
      bus.in_valid = 1'b1;
      acc = -1;
      for (int k = 0; k < 50; k++) begin
         if (bus.in_ready) begin
            @(posedge clk); #1;
            acc = cyc;
            break;
         end
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      if (acc < 0) begin
         checks++; errors++;
         $display("FAIL accept_timeout: in_ready stayed 0 for 50 cycles, expected an accept");
      end
   endtask

   // Monitor: one line per observed commit/error event.
   always @(negedge clk) begin
      if (reset === 1'b0 && (bus.wb_reg_en || bus.wb_MD_complete || bus.wb_mem_err)) begin
         $display("cyc %0d: reg_en=%b waddr=%0d wdata=%h md=%b md_result=%h err=%b",
                  cyc, bus.wb_reg_en, bus.wb_reg_waddr, bus.wb_reg_wdata,
                  bus.wb_MD_complete, bus.wb_MD_result, bus.wb_mem_err);
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: cyc=%0d reg_en=%b md=%b err=%b, expected no event",
                     cyc, bus.wb_reg_en, bus.wb_MD_complete, bus.wb_mem_err);
         end else begin
            mon_e = sb.pop_front();
            if (cyc != mon_e.cyc || bus.wb_reg_en !== mon_e.reg_en ||
                bus.wb_MD_complete !== mon_e.md || bus.wb_mem_err !== mon_e.err ||
                (mon_e.reg_en && (bus.wb_reg_waddr !== mon_e.waddr || bus.wb_reg_wdata !== mon_e.wdata)) ||
                (mon_e.md && bus.wb_MD_result !== mon_e.md_result)) begin
               errors++;
               $display("FAIL commit_tag%0d: got cyc=%0d en=%b wa=%0d wd=%h md=%b mdr=%h err=%b, expected cyc=%0d en=%b wa=%0d wd=%h md=%b mdr=%h err=%b",
                        mon_e.tag, cyc, bus.wb_reg_en, bus.wb_reg_waddr, bus.wb_reg_wdata,
                        bus.wb_MD_complete, bus.wb_MD_result, bus.wb_mem_err,
                        mon_e.cyc, mon_e.reg_en, mon_e.waddr, mon_e.wdata, mon_e.md,
                        mon_e.md_result, mon_e.err);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int a, a2;
      ld_tab[0]  = '{LOAD_LB,  2'd3, 32'h80AA_BBCC, 32'h0,          32'hFFFF_FF80, 4'd3};
      ld_tab[1]  = '{LOAD_LBU, 2'd3, 32'h80AA_BBCC, 32'h0,          32'h0000_0080, 4'd1};
      ld_tab[2]  = '{LOAD_LWL, 2'd1, 32'h1122_3344, 32'hAABB_CCDD,  32'h3344_CCDD, 4'd0};
      ld_tab[3]  = '{LOAD_LWR, 2'd1, 32'h1122_3344, 32'hAABB_CCDD,  32'hAA11_2233, 4'd2};
      ld_tab[4]  = '{LOAD_LH,  2'd2, 32'h80AA_BBCC, 32'h0,          32'hFFFF_80AA, 4'd0};
      ld_tab[5]  = '{LOAD_LHU, 2'd0, 32'h80AA_BBCC, 32'h0,          32'h0000_BBCC, 4'd1};
      ld_tab[6]  = '{LOAD_LH,  2'd1, 32'h80AA_BBCC, 32'h0,          32'h0000_0000, 4'd0};
      ld_tab[7]  = '{LOAD_LW,  2'd0, 32'hDEAD_BEEF, 32'h0,          32'hDEAD_BEEF, 4'd0};
      ld_tab[8]  = '{3'd7,     2'd0, 32'hDEAD_BEEF, 32'h0,          32'h0000_0000, 4'd0};
      ld_tab[9]  = '{LOAD_LWL, 2'd3, 32'h1122_3344, 32'hAABB_CCDD,  32'h1122_3344, 4'd0};
      ld_tab[10] = '{LOAD_LWR, 2'd3, 32'h1122_3344, 32'hAABB_CCDD,  32'hAABB_CC11, 4'd0};
      ld_tab[11] = '{LOAD_LB,  2'd1, 32'h80AA_BBCC, 32'h0,          32'hFFFF_FFBB, 4'd2};

      reset = 1'b1;
      bus.stop = 1'b0; bus.in_valid = 1'b0; bus.in_reg_en = 1'b0; bus.in_reg_waddr = '0;
      bus.in_mem_read = 1'b0; bus.in_load_type = '0; bus.in_alu_result = '0; bus.in_rt_data = '0;
      bus.in_MD_complete = 1'b0; bus.in_MD_result = '0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;

      repeat (2) @(posedge clk);
      #1;
      check("rst_reg_en", 64'(bus.wb_reg_en), 64'd0);
      check("rst_md", 64'(bus.wb_MD_complete), 64'd0);
      check("rst_err", 64'(bus.wb_mem_err), 64'd0);
      check("rst_wdata", 64'(bus.wb_reg_wdata), 64'd0);
      reset = 1'b0;
      #1;
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);

      // ALU ops back to back
      issue(1'b1, 6'd5, 1'b0, 3'd0, 32'h1234_5678, 32'h0, 1'b0, 64'h0, a);
      push_exp(a, 1'b1, 6'd5, 32'h1234_5678, 1'b0, 64'h0, 1'b0, 1);
      check("b2b_in_ready", 64'(bus.in_ready), 64'd1);
      issue(1'b1, 6'd6, 1'b0, 3'd0, 32'hCAFE_0001, 32'h0, 1'b0, 64'h0, a2);
      push_exp(a2, 1'b1, 6'd6, 32'hCAFE_0001, 1'b0, 64'h0, 1'b0, 2);
      check("b2b_throughput", 64'(a2 - a), 64'd1);
      @(posedge clk); #1;

      // Loads with varying response delay
      for (int i = 0; i < 12; i++) begin
         if (i == 1) begin
            bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h5A5A_5A5A;
         end
         issue(1'b1, 6'(8 + i), 1'b1, ld_tab[i].lt, {30'h400, ld_tab[i].off}, ld_tab[i].rt,
               1'b0, 64'h0, a);
         bus.mem_rvalid = 1'b0;
         if (i == 0) bus.stop = 1'b1;
         for (int k = 0; k < int'(ld_tab[i].d); k++) begin
            @(posedge clk); #1;
         end
         bus.stop = 1'b0;
         bus.mem_rvalid = 1'b1; bus.mem_rdata = ld_tab[i].rd;
         push_exp(cyc + 1, 1'b1, 6'(8 + i), ld_tab[i].exp, 1'b0, 64'h0, 1'b0, 10 + i);
         @(posedge clk); #1;
         bus.mem_rvalid = 1'b0;
      end
      @(posedge clk); #1;

      // Stall in COMMIT for three cycles
      issue(1'b1, 6'd20, 1'b0, 3'd0, 32'h0BAD_F00D, 32'h0, 1'b0, 64'h0, a);
      bus.stop = 1'b1;
      push_exp(a + 3, 1'b1, 6'd20, 32'h0BAD_F00D, 1'b0, 64'h0, 1'b0, 30);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("stall_reg_en", 64'(bus.wb_reg_en), 64'd0);
         check("stall_in_ready", 64'(bus.in_ready), 64'd0);
         check("stall_wdata", 64'(bus.wb_reg_wdata), 64'h0BAD_F00D);
         check("stall_waddr", 64'(bus.wb_reg_waddr), 64'd20);
      end
      @(posedge clk); #1;
      bus.stop = 1'b0;
      @(posedge clk); #1;

      // Load timeout
      issue(1'b1, 6'd25, 1'b1, LOAD_LW, 32'h0000_2000, 32'h0, 1'b0, 64'h0, a);
      push_exp(a + TIMEOUT, 1'b0, 6'd0, 32'h0, 1'b0, 64'h0, 1'b1, 40);
      for (int k = 0; k < TIMEOUT + 4; k++) begin
         @(posedge clk); #1;
      end
      check("timeout_in_ready", 64'(bus.in_ready), 64'd1);

      // HI/LO result
      issue(1'b0, 6'd0, 1'b0, 3'd0, 32'h0000_7777, 32'h0, 1'b1, 64'h0000_0001_FFFF_FFFE, a);
      push_exp(a, 1'b0, 6'd0, 32'h0, 1'b1, 64'h0000_0001_FFFF_FFFE, 1'b0, 50);
      repeat (3) @(posedge clk);
      #1;

      // Asynchronous reset during WAIT_MEM
      issue(1'b1, 6'd30, 1'b1, LOAD_LW, 32'h0000_3000, 32'h0, 1'b0, 64'h0, a);
      @(posedge clk); #1;
      check("wait_in_ready", 64'(bus.in_ready), 64'd0);
      @(negedge clk); #1;
      reset = 1'b1;
      #1;
      check("areset_in_ready", 64'(bus.in_ready), 64'd1);
      check("areset_wdata", 64'(bus.wb_reg_wdata), 64'd0);
      check("areset_waddr", 64'(bus.wb_reg_waddr), 64'd0);
      check("areset_md_result", 64'(bus.wb_MD_result), 64'd0);
      check("areset_err", 64'(bus.wb_mem_err), 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      for (int k = 0; k < TIMEOUT + 4; k++) begin
         @(posedge clk); #1;
      end
      check("post_reset_in_ready", 64'(bus.in_ready), 64'd1);

      check("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/wb_stage_pipe.md
Name: wb_stage_pipe

Overview:
Next-generation writeback stage. It accepts one retiring instruction per handshake from the mem stage and waits a variable number of cycles for the memory read response. It aligns and extends load data (LW/LB/LBU/LH/LHU/LWL/LWR), then commits to the register file and HI/LO path. Sits between the mem stage and the regfile; replaces the purely combinational writeback with a buffered, stall-aware, timeout-protected stage.

Parameters:
REG_AW, 6, register write-address width
MD_W, 64, multiply/divide result width (HI:LO)
TIMEOUT, 16, max cycles waited in WAIT_MEM before abort (2..255)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
stop  in  1  downstream stall; blocks commit
in_valid  in  1  mem stage offers an instruction
in_ready  out  1  stage can accept this cycle
in_reg_en  in  1  instruction writes a GPR
in_reg_waddr  in  REG_AW  destination register
in_mem_read  in  1  instruction is a load
in_load_type  in  3  LW=0 LB=1 LBU=2 LH=3 LHU=4 LWL=5 LWR=6
in_alu_result  in  32  ALU result / load address
in_rt_data  in  32  old rt value for LWL/LWR merge
in_MD_complete  in  1  MD result valid
in_MD_result  in  MD_W  MD result
mem_rvalid  in  1  read-data response valid
mem_rdata  in  32  read data
wb_reg_en  out  1  GPR write enable
wb_reg_waddr  out  REG_AW  GPR write address
wb_reg_wdata  out  32  GPR write data
wb_MD_complete  out  1  HI/LO write strobe
wb_MD_result  out  MD_W  HI/LO data
wb_mem_err  out  1  one-cycle pulse on load timeout

Behaviour:
- Reset (async, active-high): state=IDLE; all held fields, timeout counter, wb_reg_en, wb_MD_complete and wb_mem_err = 0; in_ready=1 after release.
- States: IDLE, WAIT_MEM, COMMIT.
- in_ready = (state==IDLE) | (state==COMMIT & ~stop). Accept = in_valid & in_ready; all in_* fields are latched on accept.
- On accept: in_mem_read=1 -> WAIT_MEM with counter cleared; otherwise -> COMMIT, with wdata = in_alu_result.
- WAIT_MEM: mem_rvalid=1 -> latch the aligned/extended load result, -> COMMIT. Otherwise the counter increments; at count TIMEOUT-1 with no rvalid: pulse wb_mem_err for 1 cycle, clear held reg_en and MD_complete, wdata=0, -> COMMIT.
- mem_rvalid is ignored outside WAIT_MEM, including the accept cycle. Memory responds at the earliest 1 cycle after accept.
- COMMIT: outputs are driven from held registers. wb_reg_en = held_reg_en & ~stop; wb_MD_complete = held_MD & ~stop.
  - stop=1: hold state and data unchanged.
  - stop=0: retire. A simultaneous accept loads the new entry (back-to-back, throughput 1/cycle for non-loads); with no accept -> IDLE.
- Outside COMMIT, wb_reg_en = wb_MD_complete = 0.
- Latency: non-load commits 1 cycle after accept. Load commits 1 cycle after mem_rvalid.
- Alignment uses off = in_alu_result[1:0]:
  - Byte: mem_rdata lane off.
  - Half: lane 0 if off=0, upper half if off=2; off odd gives 0.
  - LWL, off 0..3: {rd[7:0],rt[23:0]}, {rd[15:0],rt[15:0]}, {rd[23:0],rt[7:0]}, rd.
  - LWR, off 0..3: rd, {rt[31:24],rd[31:8]}, {rt[31:16],rd[31:16]}, {rt[31:8],rd[31:24]}.
  - Undefined load_type gives 0.
- stop during WAIT_MEM: no effect; a response is still captured.

Optional Feature:
WB_FWD_EN. When defined, add outputs fwd_valid (1), fwd_waddr (REG_AW) and fwd_wdata (32).
- fwd_valid = (state==COMMIT) & held_reg_en, independent of stop, so decode can bypass a stalled commit.
- fwd_valid also flags a load in WAIT_MEM as pending, via output fwd_pending=1, so the hazard unit can stall.
When not defined, these ports are absent and behaviour is otherwise identical.

Decomposition:
- Shared package wb_pkg: load-type constants (LOAD_LW..LOAD_LWR), the state encoding, and the default TIMEOUT.
- One sub-module, wb_load_align: purely combinational alignment/extension (type, off, rdata, rt -> 32-bit result), instantiated once and reused by the mem stage for store-data checks.

Test Plan:
- ALU op: accept in_reg_en=1, waddr=5, alu=0x1234_5678, stop=0 -> next cycle wb_reg_en=1, waddr=5, wdata=0x1234_5678; in_ready stays 1 for back-to-back.
- LB, off=3, rvalid 4 cycles later with rdata=0x80AA_BBCC -> commit cycle after rvalid, wdata=0xFFFF_FF80; LBU gives 0x0000_0080.
- LWL, off=1, rdata=0x1122_3344, rt=0xAABB_CCDD -> wdata=0x3344_CCDD; LWR with the same inputs -> 0xAA11_2233.
- stop=1 for 3 cycles in COMMIT -> wb_reg_en=0, in_ready=0, data held; stop drops -> single write of the held data.
- Load with no rvalid, TIMEOUT=16 -> wb_mem_err pulses once 16 cycles after accept, no GPR write, in_ready back to 1.
- MD: in_MD_complete=1, result=0x0000_0001_FFFF_FFFE -> wb_MD_complete=1 for one cycle with that value. Reset asserted mid-WAIT_MEM -> IDLE immediately, all outputs 0.
